// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Data-memory access unit for the MIPS core. Accepts one load/store at a time
// over a valid/ready handshake and performs it on an internal synchronous
// word RAM. Generates byte lanes, merges partial stores, sign/zero-extends
// partial loads (little-endian). Misaligned, out-of-range and illegal
// requests are answered with an exception code and the faulting address and
// never touch memory.
//
// Parameters
//   DEPTH_LOG2  RAM holds 2**DEPTH_LOG2 32-bit words
//   RD_LAT      RAM read latency in cycles, 1..4
//   ADDR_CHECK  1: addresses beyond the RAM fault; 0: word address wraps
//
// Ports
//   clk            rising-edge clock
//   resetn         synchronous active-low reset
//   req_valid      request present
//   req_ready      unit idle, request can be accepted
//   req_op         MIPS opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   req_addr       byte address
//   req_wdata      store data (low byte/half/word used)
//   resp_valid     response present
//   resp_ready     consumer takes the response
//   resp_rdata     extended load data, 0 for stores and exceptions
//   resp_exc       00 ok, 01 AdEL, 10 AdES, 11 illegal op
//   resp_badvaddr  address of faulting request, 0 when resp_exc is 00
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DEPTH_LOG2 = 14,
    parameter int RD_LAT     = 1,
    parameter int ADDR_CHECK = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic [31:0] resp_badvaddr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP      = 2'd2;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_ADEL = 2'b01;
    localparam logic [1:0] EXC_ADES = 2'b10;
    localparam logic [1:0] EXC_ILL  = 2'b11;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    // state
    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [5:0]  op_q;
    logic [1:0]  ofs_q;
    logic [1:0]  exc_q;
    logic [31:0] bad_q;
    logic [31:0] rd_word;

    logic [31:0] mem [0:DEPTH-1];

    // request decode
    logic                  is_load;
    logic                  is_store;
    logic                  is_legal;
    logic [1:0]            sz;
    logic                  misalign;
    logic                  out_of_range;
    logic [1:0]            exc_c;
    logic [3:0]            be_c;
    logic [31:0]           wdata_rep;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  accept;
    logic                  we;
    logic                  re;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_legal = 1'b1;
        sz       = SZ_WORD;
        case (req_op)
            OP_LB:   begin is_load  = 1'b1; sz = SZ_BYTE; end
            OP_LBU:  begin is_load  = 1'b1; sz = SZ_BYTE; end
            OP_LH:   begin is_load  = 1'b1; sz = SZ_HALF; end
            OP_LHU:  begin is_load  = 1'b1; sz = SZ_HALF; end
            OP_LW:   begin is_load  = 1'b1; sz = SZ_WORD; end
            OP_SB:   begin is_store = 1'b1; sz = SZ_BYTE; end
            OP_SH:   begin is_store = 1'b1; sz = SZ_HALF; end
            OP_SW:   begin is_store = 1'b1; sz = SZ_WORD; end
            default: is_legal = 1'b0;
        endcase
    end

    always_comb begin
        misalign = ((sz == SZ_HALF) && req_addr[0]) ||
                   ((sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
        // Any address bit above the RAM's byte range set means out of range.
        out_of_range = (ADDR_CHECK != 0) &&
                       ((req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
        if (!is_legal)
            exc_c = EXC_ILL;
        else if (misalign || out_of_range)
            exc_c = is_load ? EXC_ADEL : EXC_ADES;
        else
            exc_c = EXC_NONE;
    end

    always_comb begin
        be_c      = '0;
        wdata_rep = req_wdata;
        case (sz)
            SZ_BYTE: begin
                be_c      = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_c      = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c      = '1;
                wdata_rep = req_wdata;
            end
        endcase
    end

    // Word index drops the byte offset; upper bits are ignored, which gives
    // the wrap behaviour when range checking is off.
    assign widx   = req_addr[DEPTH_LOG2+1:2];
    assign accept = resetn && req_valid && (state == S_IDLE);
    assign we     = accept && is_store && (exc_c == EXC_NONE);
    assign re     = accept && is_load  && (exc_c == EXC_NONE);

    // RAM: contents are never reset. rd_word is the RAM output register;
    // the remaining RD_LAT-1 cycles of latency are spent in LOAD_WAIT.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_c[b])
                    mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
        if (re)
            rd_word <= mem[widx];
    end

    // control FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            ofs_q <= '0;
            exc_q <= EXC_NONE;
            bad_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= req_op;
                        ofs_q <= req_addr[1:0];
                        exc_q <= exc_c;
                        bad_q <= (exc_c != EXC_NONE) ? req_addr : '0;
                        if (re && (RD_LAT > 1)) begin
                            state <= S_LOAD_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    if (cnt <= 3'd1) begin
                        cnt   <= '0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // response formatting
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        byte_sel  = 8'(rd_word >> {ofs_q, 3'b000});
        half_sel  = 16'(rd_word >> {ofs_q[1], 4'b0000});
        load_data = '0;
        case (op_q)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            OP_LW:   load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    assign req_ready     = (state == S_IDLE);
    assign resp_valid    = (state == S_RESP);
    assign resp_exc      = resp_valid ? exc_q : EXC_NONE;
    assign resp_badvaddr = resp_valid ? bad_q : '0;
    assign resp_rdata    = (resp_valid && (exc_q == EXC_NONE)) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Three instances cover RD_LAT=1 with
// range checking (0), RD_LAT=3 with range checking (1), and RD_LAT=1 in wrap
// mode (2).
module tb_mem_access_unit;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        resetn [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [5:0]  req_op [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic [1:0]  resp_exc [3];
    logic [31:0] resp_badvaddr [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.DEPTH_LOG2(14), .RD_LAT(1), .ADDR_CHECK(1)) u_lat1 (
        .clk(clk), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_exc(resp_exc[0]), .resp_badvaddr(resp_badvaddr[0]));

    mem_access_unit #(.DEPTH_LOG2(14), .RD_LAT(3), .ADDR_CHECK(1)) u_lat3 (
        .clk(clk), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_exc(resp_exc[1]), .resp_badvaddr(resp_badvaddr[1]));

    mem_access_unit #(.DEPTH_LOG2(14), .RD_LAT(1), .ADDR_CHECK(0)) u_wrap (
        .clk(clk), .resetn(resetn[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_op(req_op[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
        .resp_exc(resp_exc[2]), .resp_badvaddr(resp_badvaddr[2]));

    // Issue one request on instance d and wait for its response. Returns the
    // response fields as seen at the first negedge with resp_valid high, the
    // number of cycles from accept to response, and the accept cycle number.
    task automatic do_req(input int d, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic [1:0] exc, output logic [31:0] bad,
                          output int lat, output int acc);
        int n;
        @(negedge clk);
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: inst %0d req_ready=%b expected 1", d, req_ready[d]);
        end
        req_op[d]    = op;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid[d] !== 1'b1 && lat < 20);
        if (lat >= 20) begin
            checks++; errors++;
            $display("FAIL resp_timeout: inst %0d resp_valid=%b expected 1", d, resp_valid[d]);
        end
        rdata = resp_rdata[d];
        exc   = resp_exc[d];
        bad   = resp_badvaddr[d];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            resetn[i] = 1'b0; req_valid[i] = 1'b0; resp_ready[i] = 1'b1;
            req_op[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) resetn[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_req_ready[%0d]: got %b expected 1", i, req_ready[i]); end
            checks++;
            if (resp_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d]: got %b expected 0", i, resp_valid[i]); end
            checks++;
            if (resp_rdata[i] !== 32'd0 || resp_exc[i] !== 2'b00 || resp_badvaddr[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_resp_fields[%0d]: got rdata=%h exc=%b bad=%h expected 0/00/0",
                         i, resp_rdata[i], resp_exc[i], resp_badvaddr[i]);
            end
        end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] rd, bad; logic [1:0] exc; int lat, acc;
        do_req(0, SW, 32'h10, 32'hDEADBEEF, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b00 || rd !== 32'd0 || lat != 1) begin errors++; $display("FAIL sw_0x10: got exc=%b rdata=%h lat=%0d expected 00/0/1", exc, rd, lat); end
        do_req(0, LW, 32'h10, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'hDEADBEEF || exc !== 2'b00) begin errors++; $display("FAIL lw_0x10: got %h exc=%b expected deadbeef exc=00", rd, exc); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL lw_latency_1: got %0d expected 1", lat); end
        do_req(1, SW, 32'h10, 32'hDEADBEEF, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b00 || lat != 1) begin errors++; $display("FAIL sw_lat3_inst: got exc=%b lat=%0d expected 00/1", exc, lat); end
        do_req(1, LW, 32'h10, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'hDEADBEEF || exc !== 2'b00) begin errors++; $display("FAIL lw_lat3_data: got %h expected deadbeef", rd); end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL lw_latency_3: got %0d expected 3", lat); end
    endtask

    task automatic test_partial();
        logic [31:0] rd, bad; logic [1:0] exc; int lat, acc;
        do_req(0, SB, 32'h11, 32'hAAAAAA80, rd, exc, bad, lat, acc);
        do_req(0, LW, 32'h10, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'hDEAD80EF) begin errors++; $display("FAIL sb_merge: got %h expected dead80ef", rd); end
        do_req(0, LB, 32'h11, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h expected ffffff80", rd); end
        do_req(0, LBU, 32'h11, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h expected 00000080", rd); end
        do_req(0, SH, 32'h12, 32'h55551234, rd, exc, bad, lat, acc);
        do_req(0, LW, 32'h10, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'h123480EF) begin errors++; $display("FAIL sh_merge: got %h expected 123480ef", rd); end
        do_req(0, LH, 32'h12, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_upper: got %h expected 00001234", rd); end
        do_req(0, LH, 32'h10, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'hFFFF80EF) begin errors++; $display("FAIL lh_sext: got %h expected ffff80ef", rd); end
        do_req(0, LHU, 32'h10, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'h000080EF) begin errors++; $display("FAIL lhu_zext: got %h expected 000080ef", rd); end
        do_req(0, LB, 32'h13, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'h00000012) begin errors++; $display("FAIL lb_lane3: got %h expected 00000012", rd); end
    endtask

    task automatic test_exceptions();
        logic [31:0] rd, bad; logic [1:0] exc; int lat, acc;
        do_req(0, LW, 32'h13, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b01 || bad !== 32'h13 || rd !== 32'd0) begin errors++; $display("FAIL lw_misalign: got exc=%b bad=%h rdata=%h expected 01/13/0", exc, bad, rd); end
        do_req(0, SW, 32'h20, 32'hCAFEF00D, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b00 || bad !== 32'd0) begin errors++; $display("FAIL sw_0x20: got exc=%b bad=%h expected 00/0", exc, bad); end
        do_req(0, SH, 32'h21, 32'h0000FFFF, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b10 || bad !== 32'h21 || lat != 1) begin errors++; $display("FAIL sh_misalign: got exc=%b bad=%h lat=%0d expected 10/21/1", exc, bad, lat); end
        do_req(0, LW, 32'h20, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL sh_misalign_nowrite: got %h expected cafef00d", rd); end
        do_req(0, 6'h00, 32'h44, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b11 || bad !== 32'h44) begin errors++; $display("FAIL illegal_op: got exc=%b bad=%h expected 11/44", exc, bad); end
        do_req(0, LW, 32'h00010000, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b01 || bad !== 32'h00010000) begin errors++; $display("FAIL lw_range: got exc=%b bad=%h expected 01/00010000", exc, bad); end
        do_req(0, SW, 32'h00010020, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b10 || bad !== 32'h00010020) begin errors++; $display("FAIL sw_range: got exc=%b bad=%h expected 10/00010020", exc, bad); end
        do_req(0, LH, 32'h22, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'hFFFFCAFE || exc !== 2'b00) begin errors++; $display("FAIL sw_range_nowrite: got %h exc=%b expected ffffcafe/00", rd, exc); end
        do_req(2, LW, 32'h13, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b01 || bad !== 32'h13) begin errors++; $display("FAIL wrap_misalign: got exc=%b bad=%h expected 01/13", exc, bad); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, bad; logic [1:0] exc; int lat, acc;
        do_req(2, SW, 32'h00010004, 32'd5, rd, exc, bad, lat, acc);
        checks++;
        if (exc !== 2'b00) begin errors++; $display("FAIL wrap_sw_exc: got %b expected 00", exc); end
        do_req(2, LW, 32'h4, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'd5 || exc !== 2'b00) begin errors++; $display("FAIL wrap_lw: got %h exc=%b expected 00000005/00", rd, exc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, bad; logic [1:0] exc; int lat, acc, n;
        resp_ready[0] = 1'b0;
        do_req(0, LW, 32'h10, 32'h0, rd, exc, bad, lat, acc);
        // second request waits behind the held response
        req_op[0] = LW; req_addr[0] = 32'h20; req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h123480EF || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b expected 1/123480ef/0",
                         k, resp_valid[0], resp_rdata[0], req_ready[0]);
            end
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", req_ready[0], resp_valid[0]); end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (resp_valid[0] !== 1'b1 && n < 20);
        checks++;
        if (resp_rdata[0] !== 32'hCAFEF00D || n != 1) begin errors++; $display("FAIL bp_second: got rdata=%h lat=%0d expected cafef00d/1", resp_rdata[0], n); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, bad; logic [1:0] exc; int lat, a1, a2;
        do_req(0, SW, 32'h40, 32'd1, rd, exc, bad, lat, a1);
        do_req(0, SW, 32'h44, 32'd2, rd, exc, bad, lat, a2);
        checks++;
        if (a2 - a1 != 2) begin errors++; $display("FAIL b2b_store: got %0d cycles expected 2", a2 - a1); end
        do_req(0, LW, 32'h40, 32'h0, rd, exc, bad, lat, a1);
        do_req(0, LW, 32'h44, 32'h0, rd, exc, bad, lat, a2);
        checks++;
        if (a2 - a1 != 2 || rd !== 32'd2) begin errors++; $display("FAIL b2b_load_lat1: got %0d cycles rdata=%h expected 2/00000002", a2 - a1, rd); end
        do_req(1, LW, 32'h10, 32'h0, rd, exc, bad, lat, a1);
        do_req(1, LW, 32'h10, 32'h0, rd, exc, bad, lat, a2);
        checks++;
        if (a2 - a1 != 4) begin errors++; $display("FAIL b2b_load_lat3: got %0d cycles expected 4", a2 - a1); end
    endtask

    task automatic test_reset_midload();
        logic [31:0] rd, bad; logic [1:0] exc; int lat, acc;
        do_req(1, SW, 32'h30, 32'h11223344, rd, exc, bad, lat, acc);
        @(negedge clk);
        req_op[1] = LW; req_addr[1] = 32'h30; req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        // reset lands on the edge after accept; a store is offered throughout
        resetn[1] = 1'b0;
        req_op[1] = SW; req_addr[1] = 32'h30; req_wdata[1] = 32'h0; req_valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn[1] = 1'b1;
        req_valid[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL midload_abort[%0d]: got valid=%b ready=%b expected 0/1", k, resp_valid[1], req_ready[1]);
            end
            @(negedge clk);
        end
        do_req(1, LW, 32'h30, 32'h0, rd, exc, bad, lat, acc);
        checks++;
        if (rd !== 32'h11223344 || exc !== 2'b00 || lat != 3) begin errors++; $display("FAIL midload_after: got %h exc=%b lat=%0d expected 11223344/00/3", rd, exc, lat); end
    endtask

    initial begin
        test_reset();
        test_word_roundtrip();
        test_partial();
        test_exceptions();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised data-memory access unit for the MIPS core: accepts one load/store request at a time over a valid/ready handshake and performs it on an internal synchronous word RAM with configurable read latency. It generates byte lanes, merges partial stores and sign/zero-extends partial loads (little-endian throughout). It also detects misaligned, out-of-range and illegal accesses, returning an exception code and the faulting address instead of touching memory. It sits between the MEM pipeline stage and the data RAM, replacing the combinational lane logic with a stallable, latency-tolerant interface.

## Interface
- DEPTH_LOG2, 14: RAM holds 2^DEPTH_LOG2 32-bit words.
- RD_LAT, 1: RAM read latency in cycles; legal values are 1 to 4.
- ADDR_CHECK, 1: 1 = addresses beyond the RAM raise an exception; 0 = word address wraps modulo 2^DEPTH_LOG2.
- clk  in  1  sole clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  6  MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte, half or word is used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  2  00 ok, 01 AdEL, 10 AdES, 11 illegal op.
- resp_badvaddr  out  32  req_addr of the faulting request; 0 when resp_exc is 00.

## Operation
- States: IDLE, LOAD_WAIT, RESP. req_ready = (state == IDLE).
- Accept: a request is accepted on a rising edge where req_valid && req_ready. The unit registers op, addr[1:0] and the exception result.
- Exception check, evaluated at accept:
  - illegal op gives 11;
  - LH/LHU with addr[0]=1, or LW with addr[1:0]≠0, gives 01;
  - SH/SW misaligned the same way gives 10;
  - if ADDR_CHECK=1 and addr[31:DEPTH_LOG2+2]≠0, loads give 01 and stores give 10.
  - An excepting request never writes the RAM and goes IDLE→RESP.
- Store without exception: the RAM is written on the accept edge.
  - Byte enables: SB gives 1<<addr[1:0]; SH gives 0011 (addr[1]=0) or 1100 (addr[1]=1); SW gives 1111.
  - Data is replicated across lanes.
  - Next state is RESP.
- Load without exception: the RAM read is issued on the accept edge.
  - RD_LAT=1 goes IDLE→RESP.
  - Otherwise the FSM goes to LOAD_WAIT, where a counter counts down RD_LAT-1 cycles, then RESP.
  - Lane select: byte = word[8*addr[1:0] +: 8]; half = word[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP: resp_valid=1 and all resp_* outputs are held stable until resp_valid && resp_ready, then the FSM returns to IDLE. resp_ready is ignored outside RESP.
- RAM contents are not initialised and are not cleared by reset.

## Timing
- Reset (resetn=0 at an edge):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_exc=00, resp_badvaddr=0.
  - req_ready=1 in the first cycle after reset.
- Store or exception accepted at edge T: resp_valid is high from T+1.
- Load accepted at edge T: resp_valid is high from T+RD_LAT.
- With resp_ready held at 1:
  - stores sustain one access every 2 cycles;
  - loads sustain one access every RD_LAT+1 cycles.
- Back-to-back: req_ready rises in the cycle after the response handshake edge. There is no same-cycle re-accept.
- Reset mid-operation:
  - The FSM aborts to IDLE and the pending response is discarded.
  - A store accepted before reset stays written.
  - No write occurs during any cycle with resetn=0, even if req_valid=1.
- Load after store to the same word: the load returns the post-store value, since the write completes before any later read issues.
- req_valid while req_ready=0: the request is not accepted. The requester must hold it; the unit has no internal queue.

## Test plan
- Word round-trip:
  - SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → resp_rdata 0xDEADBEEF, exc 00.
  - Load response arrives exactly RD_LAT cycles after accept; check for RD_LAT=1 and RD_LAT=3.
- Partial store and extension (word 0x10 = 0xDEADBEEF from the previous test):
  - SB 0x11 data 0x80 → word 0xDEAD80EF.
  - LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080.
  - SH 0x12 data 0x1234 → word 0x123480EF; LH 0x12 → 0x00001234.
- Exceptions:
  - LW 0x13 → exc 01, badvaddr 0x13.
  - SH 0x21 → exc 10, memory unchanged.
  - Opcode 0x00 → exc 11.
  - With ADDR_CHECK=1 and DEPTH_LOG2=14, LW 0x00010000 → exc 01.
- Wrap mode: with ADDR_CHECK=0 and DEPTH_LOG2=14, SW 0x00010004 data 5, then LW 0x4 → 5, exc 00.
- Backpressure: hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata are stable throughout, req_ready=0, and a second req_valid is not accepted until after the handshake.
- Reset mid-load: RD_LAT=3, assert resetn=0 one cycle after accept → resp_valid stays 0 and req_ready=1 after release. A following LW returns the stored data unchanged.
